// File: rtl/dircc_rx_pkg.sv
// Shared FSM encoding and slot-layout helpers for the DiRCC node receive path.
// A slot is one length word followed by payload words, laid out back to back.
package dircc_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      COMMIT = 2'd2,
      DROP   = 2'd3
   } rx_state_t;

   localparam int LEN_WORD           = 0;
   localparam int FIRST_PAYLOAD_WORD = 1;
   localparam int MEM_SPAN_LIMIT     = 20480;

   function automatic int unsigned slot_word_addr(
      input int unsigned base,
      input int unsigned slot,
      input int unsigned slot_words,
      input int unsigned word
   );
      return base + slot * slot_words + word;
   endfunction

endpackage

// File: rtl/dircc_slot_ring.sv
// Ring bookkeeping: write/read slot pointers and the count of published slots.
// A committed slot is held as pending for one cycle so it is published after its length word lands.
module dircc_slot_ring #(
   parameter int NUM_SLOTS = 8
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_commit,
   input  logic                         i_release,
   output logic [$clog2(NUM_SLOTS)-1:0] o_wr_slot,
   output logic [$clog2(NUM_SLOTS)-1:0] o_rd_slot,
   output logic [$clog2(NUM_SLOTS):0]   o_slots_used,
   output logic                         o_free
);
   localparam int SLOT_W = $clog2(NUM_SLOTS);
   localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);
   localparam logic [SLOT_W:0]   USED_ONE = (SLOT_W + 1)'(1);

   logic [SLOT_W-1:0] r_wr_slot;
   logic [SLOT_W-1:0] r_rd_slot;
   logic [SLOT_W:0]   r_slots_used;
   logic              r_pending;
   logic              w_release;
   logic [SLOT_W+1:0] w_occupied;

   assign w_release  = i_release && (r_slots_used != '0);
   assign w_occupied = {1'b0, r_slots_used} + (SLOT_W + 2)'(r_pending);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_slot    <= '0;
         r_rd_slot    <= '0;
         r_slots_used <= '0;
         r_pending    <= 1'b0;
      end else begin
         r_pending <= i_commit;
         if (i_commit) begin
            r_wr_slot <= r_wr_slot + SLOT_ONE;
         end
         if (w_release) begin
            r_rd_slot <= r_rd_slot + SLOT_ONE;
         end
         // Simultaneous publish and release cancel out in the count.
         if (r_pending && !w_release) begin
            r_slots_used <= r_slots_used + USED_ONE;
         end else if (!r_pending && w_release) begin
            r_slots_used <= r_slots_used - USED_ONE;
         end
      end
   end

   assign o_wr_slot    = r_wr_slot;
   assign o_rd_slot    = r_rd_slot;
   assign o_slots_used = r_slots_used;
   assign o_free       = (w_occupied < (SLOT_W + 2)'(NUM_SLOTS));

endmodule

// File: rtl/dircc_node_rx_mem_writer.sv
// Receive DMA: writes ingress packets into a ring of slots in processing memory,
// payload first and length word last, then hands the slot to the CPU.
module dircc_node_rx_mem_writer
   import dircc_rx_pkg::*;
#(
   parameter int BASE_ADDR  = 16384,
   parameter int SLOT_WORDS = 64,
   parameter int NUM_SLOTS  = 8,
   parameter int ADDR_W     = 15
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic [15:0]                  i_rx_data,
   input  logic                         i_rx_valid,
   input  logic                         i_rx_sop,
   input  logic                         i_rx_eop,
   output logic                         o_rx_ready,
   output logic [ADDR_W-1:0]            o_mem_address,
   output logic [1:0]                   o_mem_byteenable,
   output logic                         o_mem_chipselect,
   output logic                         o_mem_write,
   output logic [15:0]                  o_mem_writedata,
   output logic                         o_mem_clken,
   input  logic                         i_slot_release,
   output logic [$clog2(NUM_SLOTS)-1:0] o_rd_slot,
   output logic [$clog2(NUM_SLOTS):0]   o_slots_used,
   output logic                         o_irq,
   output logic [15:0]                  o_drop_count
);
   localparam int SLOT_W = $clog2(NUM_SLOTS);
   localparam int CNT_W  = $clog2(SLOT_WORDS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(FIRST_PAYLOAD_WORD);

   generate
      if (BASE_ADDR + NUM_SLOTS * SLOT_WORDS > MEM_SPAN_LIMIT) begin : g_span_check
         $error("slot ring extends past the processing memory window");
      end
      if ((SLOT_WORDS < 2) || ((SLOT_WORDS & (SLOT_WORDS - 1)) != 0) ||
          (NUM_SLOTS < 2) || ((NUM_SLOTS & (NUM_SLOTS - 1)) != 0)) begin : g_pow2_check
         $error("SLOT_WORDS and NUM_SLOTS must be powers of two, at least 2");
      end
   endgenerate

   rx_state_t         r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_rx_ready;
   logic              r_mem_write;
   logic [ADDR_W-1:0] r_mem_address;
   logic [15:0]       r_mem_writedata;
   logic [15:0]       r_drop_count;

   logic              w_beat;
   logic              w_start;
   logic              w_commit;
   logic              w_free;
   logic [SLOT_W-1:0] w_wr_slot;
   logic [ADDR_W-1:0] w_addr_first;
   logic [ADDR_W-1:0] w_addr_next;
   logic [ADDR_W-1:0] w_addr_len;
   logic [15:0]       w_drop_inc;

   dircc_slot_ring #(
      .NUM_SLOTS(NUM_SLOTS)
   ) u_ring (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_commit    (w_commit),
      .i_release   (i_slot_release),
      .o_wr_slot   (w_wr_slot),
      .o_rd_slot   (o_rd_slot),
      .o_slots_used(o_slots_used),
      .o_free      (w_free)
   );

   assign w_beat     = i_rx_valid && o_rx_ready;
   assign w_commit   = (r_state == COMMIT);
   // A sop inside RECV reuses the slot it already owns, so it needs no free check.
   assign w_start    = w_beat && i_rx_sop && ((r_state == RECV) || w_free);
   assign w_drop_inc = (r_drop_count == 16'hFFFF) ? r_drop_count : r_drop_count + 16'd1;

   assign w_addr_first = ADDR_W'(slot_word_addr(BASE_ADDR, 32'(w_wr_slot), SLOT_WORDS, FIRST_PAYLOAD_WORD));
   assign w_addr_next  = ADDR_W'(slot_word_addr(BASE_ADDR, 32'(w_wr_slot), SLOT_WORDS, 32'(r_cnt) + 1));
   assign w_addr_len   = ADDR_W'(slot_word_addr(BASE_ADDR, 32'(w_wr_slot), SLOT_WORDS, LEN_WORD));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= IDLE;
         r_cnt           <= '0;
         r_rx_ready      <= 1'b1;
         r_mem_write     <= 1'b0;
         r_mem_address   <= '0;
         r_mem_writedata <= '0;
         r_drop_count    <= '0;
      end else begin
         r_mem_write <= 1'b0;
         if (w_start) begin
            r_mem_write     <= 1'b1;
            r_mem_address   <= w_addr_first;
            r_mem_writedata <= i_rx_data;
            r_cnt           <= CNT_FIRST;
            r_state         <= i_rx_eop ? COMMIT : RECV;
            r_rx_ready      <= !i_rx_eop;
            if (r_state == RECV) begin
               r_drop_count <= w_drop_inc;
            end
         end else begin
            unique case (r_state)
               IDLE, DROP: begin
                  if (w_beat && i_rx_sop) begin
                     r_drop_count <= w_drop_inc;
                     r_state      <= i_rx_eop ? IDLE : DROP;
                  end else if (w_beat && i_rx_eop) begin
                     r_state <= IDLE;
                  end
               end
               RECV: begin
                  if (w_beat) begin
                     if (r_cnt == CNT_LAST) begin
                        r_drop_count <= w_drop_inc;
                        r_state      <= i_rx_eop ? IDLE : DROP;
                     end else begin
                        r_mem_write     <= 1'b1;
                        r_mem_address   <= w_addr_next;
                        r_mem_writedata <= i_rx_data;
                        r_cnt           <= r_cnt + CNT_W'(1);
                        if (i_rx_eop) begin
                           r_state    <= COMMIT;
                           r_rx_ready <= 1'b0;
                        end
                     end
                  end
               end
               COMMIT: begin
                  r_mem_write     <= 1'b1;
                  r_mem_address   <= w_addr_len;
                  r_mem_writedata <= 16'(r_cnt);
                  r_cnt           <= '0;
                  r_state         <= IDLE;
                  r_rx_ready      <= 1'b1;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign o_rx_ready       = r_rx_ready && !i_reset;
   assign o_mem_address    = r_mem_address;
   assign o_mem_writedata  = r_mem_writedata;
   assign o_mem_write      = r_mem_write;
   assign o_mem_chipselect = r_mem_write;
   assign o_mem_byteenable = 2'b11;
   assign o_mem_clken      = 1'b1;
   assign o_irq            = (o_slots_used != '0);
   assign o_drop_count     = r_drop_count;

endmodule

// File: tb/tb_dircc_node_rx_mem_writer.sv
// Scoreboard bench: a packet-level model predicts every memory write and the ring status;
// a monitor pops predictions whenever the DUT strobes mem_write.
module tb_dircc_node_rx_mem_writer;
   localparam int BASE = 16384;
   localparam int SW   = 64;
   localparam int NS   = 8;
   localparam int AW   = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [15:0]   rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_sop = 1'b0;
   logic          rx_eop = 1'b0;
   logic          rx_ready;
   logic [AW-1:0] mem_address;
   logic [1:0]    mem_byteenable;
   logic          mem_chipselect;
   logic          mem_write;
   logic [15:0]   mem_writedata;
   logic          mem_clken;
   logic          slot_release = 1'b0;
   logic [2:0]    rd_slot;
   logic [3:0]    slots_used;
   logic          irq;
   logic [15:0]   drop_count;

   always #5 clk = ~clk;

   dircc_node_rx_mem_writer #(
      .BASE_ADDR(BASE), .SLOT_WORDS(SW), .NUM_SLOTS(NS), .ADDR_W(AW)
   ) dut (
      .i_clk(clk), .i_reset(reset),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_sop(rx_sop), .i_rx_eop(rx_eop),
      .o_rx_ready(rx_ready),
      .o_mem_address(mem_address), .o_mem_byteenable(mem_byteenable),
      .o_mem_chipselect(mem_chipselect), .o_mem_write(mem_write),
      .o_mem_writedata(mem_writedata), .o_mem_clken(mem_clken),
      .i_slot_release(slot_release), .o_rd_slot(rd_slot), .o_slots_used(slots_used),
      .o_irq(irq), .o_drop_count(drop_count)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [15:0]   d;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [15:0] flit_buf [0:127];
   int n_tests = 0;
   int n_fail  = 0;
   int n_ready_low = 0;
   // Reference model: occupied slots (published or about to be), ring pointers, drops.
   int m_wr = 0, m_rd = 0, m_used = 0, m_drops = 0;
   bit m_open = 0;

   function automatic logic [AW-1:0] waddr(input int slot, input int word);
      return AW'(BASE + slot * SW + word);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && !rx_ready) n_ready_low++;
      if (mem_write) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr=0x%h data=0x%h, required no write",
                     mem_address, mem_writedata);
         end else begin
            mon_e = exp_q.pop_front();
            $display("[TB] wr addr=0x%h data=0x%h", mem_address, mem_writedata);
            check("wr_addr", int'(mem_address), int'(mon_e.a));
            check("wr_data", int'(mem_writedata), int'(mon_e.d));
            check("wr_cs", int'(mem_chipselect), 1);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic beat(input logic [15:0] d, input bit sop, input bit eop);
      int guard = 0;
      rx_valid = 1'b1; rx_data = d; rx_sop = sop; rx_eop = eop;
      @(negedge clk);
      while (!rx_ready && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      if (!rx_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL rx_ready_timeout: got rx_ready=0 for 16 cycles, required 1");
      end
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
   endtask

   task automatic fill_random(input int len);
      for (int i = 0; i < len; i++) flit_buf[i] = 16'($urandom);
   endtask

   // close=0 leaves the packet without its eop beat.
   task automatic send_pkt(input int len, input bit close);
      bit writing;
      int cnt = 0;
      if (m_open) begin
         m_drops++;
         writing = 1;
      end else if (m_used < NS) begin
         writing = 1;
      end else begin
         writing = 0;
         m_drops++;
      end
      for (int i = 0; i < len; i++) begin
         if (writing) begin
            if (cnt == SW - 1) begin
               writing = 0;
               m_drops++;
            end else begin
               cnt++;
               exp_q.push_back({waddr(m_wr, cnt), flit_buf[i]});
            end
         end
         beat(flit_buf[i], i == 0, close && (i == len - 1));
      end
      m_open = 0;
      if (writing && close) begin
         exp_q.push_back({waddr(m_wr, 0), 16'(cnt)});
         m_wr = (m_wr + 1) % NS;
         m_used++;
      end else if (writing) begin
         m_open = 1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic release_pulse();
      slot_release = 1'b1;
      @(posedge clk); #1;
      slot_release = 1'b0;
      if (m_used > 0) begin
         m_used--;
         m_rd = (m_rd + 1) % NS;
      end
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      check({tag, "_slots_used"}, int'(slots_used), m_used);
      check({tag, "_rd_slot"}, int'(rd_slot), m_rd);
      check({tag, "_irq"}, int'(irq), int'(m_used != 0));
      check({tag, "_drop_count"}, int'(drop_count), m_drops);
      @(posedge clk); #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1; slot_release = 1'b0;
      rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
      @(negedge clk);
      check("rst_rx_ready_low", int'(rx_ready), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      m_wr = 0; m_rd = 0; m_used = 0; m_drops = 0; m_open = 0;
      @(negedge clk);
      check("rst_rx_ready", int'(rx_ready), 1);
      check("rst_mem_write", int'(mem_write), 0);
      check("rst_mem_cs", int'(mem_chipselect), 0);
      check("rst_mem_addr", int'(mem_address), 0);
      check("rst_mem_data", int'(mem_writedata), 0);
      check("rst_rd_slot", int'(rd_slot), 0);
      check("rst_slots_used", int'(slots_used), 0);
      check("rst_irq", int'(irq), 0);
      check("rst_drop_count", int'(drop_count), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int low0;
      #1;
      reset_dut();

      // Single 3-flit packet and publish timing.
      flit_buf[0] = 16'h00A1; flit_buf[1] = 16'h00A2; flit_buf[2] = 16'h00A3;
      send_pkt(3, 1);
      @(negedge clk);
      check("commit_rx_ready", int'(rx_ready), 0);
      check("commit_slots_used", int'(slots_used), 0);
      @(negedge clk);
      check("lenwrite_slots_used", int'(slots_used), 0);
      @(negedge clk);
      check("publish_slots_used", int'(slots_used), 1);
      check("publish_irq", int'(irq), 1);
      @(posedge clk); #1;
      check_status("t1");

      // Nine back-to-back 1-flit packets, no release: ring fills, ninth dropped.
      reset_dut();
      low0 = n_ready_low;
      for (int p = 0; p < 9; p++) begin
         fill_random(1);
         send_pkt(1, 1);
      end
      idle(3);
      check("fill_ready_low_cycles", n_ready_low - low0, 8);
      check_status("fill");
      for (int p = 0; p < 8; p++) release_pulse();
      idle(1);
      check_status("drain");

      // Oversized packet: 63 payload writes, no length, slot reused afterwards.
      fill_random(70);
      send_pkt(70, 1);
      idle(3);
      check_status("overflow");
      fill_random(2);
      send_pkt(2, 1);
      for (int p = 0; p < 2; p++) begin
         fill_random(1);
         send_pkt(1, 1);
      end
      idle(3);
      check_status("three_used");

      // Release in the same cycle the fourth slot publishes.
      fill_random(1);
      send_pkt(1, 1);
      @(posedge clk); #1;
      slot_release = 1'b1;
      @(posedge clk); #1;
      slot_release = 1'b0;
      m_used--;
      m_rd = (m_rd + 1) % NS;
      @(negedge clk);
      check("same_cycle_slots_used", int'(slots_used), 3);
      check("same_cycle_rd_slot", int'(rd_slot), m_rd);
      @(posedge clk); #1;
      repeat (3) release_pulse();
      release_pulse();
      idle(1);
      check_status("release_at_zero");

      // Reset in the middle of a packet.
      fill_random(5);
      send_pkt(5, 0);
      reset_dut();
      fill_random(4);
      send_pkt(4, 1);
      idle(3);
      check_status("after_mid_reset");
      release_pulse();

      // Wrap: publish and release 20 times, read pointer follows write pointer.
      for (int p = 0; p < 20; p++) begin
         fill_random($urandom_range(1, 10));
         send_pkt($urandom_range(1, 10), 1);
         idle(3);
         check_status("wrap_pub");
         release_pulse();
         @(negedge clk);
         check("wrap_rd_tracks_wr", int'(rd_slot), m_wr);
         @(posedge clk); #1;
      end

      // Random mix: abandoned packets, oversize packets, sparse releases.
      for (int p = 0; p < 40; p++) begin
         int len;
         len = ($urandom_range(0, 9) == 0) ? $urandom_range(66, 80) : $urandom_range(1, 12);
         if ($urandom_range(0, 5) == 0) begin
            fill_random(5);
            send_pkt($urandom_range(1, 5), 0);
         end
         fill_random(len);
         send_pkt(len, 1);
         idle(3);
         if ($urandom_range(0, 2) == 0) release_pulse();
         check_status("rand");
      end

      idle(5);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
